// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
//   Instruction memory whose program is streamed in at run time through a load
//   port, then served to the CPU fetch path with one-cycle synchronous-read
//   latency. Words that were never loaded read back as FILL_WORD.
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   load_start     pulse: restart loading at word 0 (any state)
//   load_valid     load_data carries a word this cycle
//   load_data      program word
//   load_last      with load_valid: this is the final program word
//   load_ready     high while loading
//   load_done      high once a load has finished (RUN)
//   fetch_req      fetch request this cycle
//   fetch_addr     byte address of the fetch
//   fetch_valid    response valid, exactly one cycle after fetch_req
//   fetch_data     fetched word (FILL_WORD on fault or unloaded word)
//   fetch_fault    misaligned or out-of-range fetch
//   dbg_state      current FSM state (0 IDLE, 1 LOAD, 2 RUN)
//
// Handshake: load_data is accepted on every rising edge where the block is in
// LOAD, load_valid=1 and load_start=0; there is no stall on the load side.
// Fetches have no backpressure: each fetch_req in RUN yields exactly one
// fetch_valid pulse on the following cycle, in request order.
// -----------------------------------------------------------------------------
module imem_loadable #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] FILL_WORD = 32'hEAFFFFFE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    output logic [1:0]        dbg_state
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [DEPTH-1:0]  loaded_q, loaded_d;
    logic              load_ready_q, load_ready_d;
    logic              load_done_q, load_done_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              fetch_fault_q, fetch_fault_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     fetch_idx;
    logic              idx_high;
    logic              fetch_bad;

    assign fetch_idx = fetch_addr[AW+1:2];

    // Because DEPTH is a power of two, idx >= DEPTH is simply "any index bit
    // above the memory index is set".
    generate
        if (ADDR_W > AW + 2) begin : g_idx_high
            assign idx_high = |fetch_addr[ADDR_W-1:AW+2];
        end else begin : g_no_idx_high
            assign idx_high = 1'b0;
        end
    endgenerate

    assign fetch_bad = (fetch_addr[1:0] != 2'b00) | idx_high;

    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        loaded_d      = loaded_q;
        load_done_d   = load_done_q;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        fetch_fault_d = fetch_fault_q;
        mem_we        = 1'b0;

        // Fetch path looks only at current contents, so a fetch coincident
        // with load_start is served from the old image.
        if (state_q == S_RUN && fetch_req) begin
            fetch_valid_d = 1'b1;
            if (fetch_bad) begin
                fetch_data_d  = FILL_WORD;
                fetch_fault_d = 1'b1;
            end else if (!loaded_q[fetch_idx]) begin
                fetch_data_d  = FILL_WORD;
                fetch_fault_d = 1'b0;
            end else begin
                fetch_data_d  = mem[fetch_idx];
                fetch_fault_d = 1'b0;
            end
        end

        // load_start wins over a same-cycle load word, which is dropped.
        if (load_start) begin
            state_d     = S_LOAD;
            wptr_d      = '0;
            loaded_d    = '0;
            load_done_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (load_valid) begin
                        mem_we           = 1'b1;
                        loaded_d[wptr_q] = 1'b1;
                        // Terminal compare: the pointer never wraps, the last
                        // slot ends the load even without load_last.
                        if (load_last || wptr_q == LAST_IDX) begin
                            state_d     = S_RUN;
                            load_done_d = 1'b1;
                        end else begin
                            wptr_d = wptr_q + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        load_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wptr_q        <= '0;
            loaded_q      <= '0;
            load_ready_q  <= 1'b0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            loaded_q      <= loaded_d;
            load_ready_q  <= load_ready_d;
            load_done_q   <= load_done_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    // Storage is not reset; the loaded vector is what makes stale words
    // unreadable after reset or reload.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= load_data;
        end
    end

    assign load_ready  = load_ready_q;
    assign load_done   = load_done_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_fault = fetch_fault_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 64;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] FILL   = 32'hEAFFFFFE;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              load_done;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loadable #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL_WORD(FILL)
    ) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_data(fetch_data), .fetch_fault(fetch_fault), .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 loading, 2 running
    int          ref_mode = 0;
    int          ref_wptr = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          ref_loaded [DEPTH];

    logic [32:0] exp_q[$];
    int          exp_cyc_q[$];

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] prog [4] = '{32'hE3A09000, 32'hE3A000C8, 32'hE3A02014, 32'hEAFFFFFE};

    function automatic logic [32:0] predict(input logic [31:0] a);
        int idx;
        if (a[1:0] != 2'b00 || a >= 32'(DEPTH * 4)) return {1'b1, FILL};
        idx = int'(a >> 2);
        if (!ref_loaded[idx]) return {1'b0, FILL};
        return {1'b0, ref_mem[idx]};
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit ls, input bit lv, input logic [31:0] ld,
                        input bit ll, input bit fr, input logic [31:0] fa);
        load_start = ls; load_valid = lv; load_data = ld; load_last = ll;
        fetch_req = fr; fetch_addr = fa;
        if (fr && ref_mode == 2) begin
            exp_q.push_back(predict(fa));
            exp_cyc_q.push_back(cyc);
        end
        if (ls) begin
            ref_mode = 1;
            ref_wptr = 0;
            foreach (ref_loaded[i]) ref_loaded[i] = 1'b0;
        end else if (ref_mode == 1 && lv) begin
            ref_mem[ref_wptr] = ld;
            ref_loaded[ref_wptr] = 1'b1;
            if (ll || ref_wptr == DEPTH - 1) ref_mode = 2;
            else ref_wptr++;
        end
        @(posedge clk);
        #1;
        check_val("load_ready", 32'(load_ready), 32'(ref_mode == 1));
        check_val("load_done", 32'(load_done), 32'(ref_mode == 2));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(0, 0, '0, 0, 1, a);
    endtask

    task automatic load_prog(input int gap);
        step(1, 0, '0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) step(0, 0, 32'hBAD0_0000 + 32'(g), 0, 0, '0);
            step(0, 1, prog[i], (i == 3), 0, '0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load_start = 0; load_valid = 0; load_last = 0; fetch_req = 0;
        exp_q.delete();
        exp_cyc_q.delete();
        ref_mode = 0;
        ref_wptr = 0;
        foreach (ref_loaded[i]) ref_loaded[i] = 1'b0;
        #2;
        check_val("rst_load_ready", 32'(load_ready), 32'd0);
        check_val("rst_load_done", 32'(load_done), 32'd0);
        check_val("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check_val("rst_fetch_data", fetch_data, 32'd0);
        check_val("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && fetch_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_response: got valid data=%h fault=%b expected no response",
                         fetch_data, fetch_fault);
            end else begin
                logic [32:0] e;
                int          c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                if ({fetch_fault, fetch_data} !== e || cyc != c + 1) begin
                    miscompares++;
                    $display("FAIL fetch_resp: got fault=%b data=%h cyc=%0d expected fault=%b data=%h cyc=%0d",
                             fetch_fault, fetch_data, cyc, e[32], e[31:0], c + 1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        bit          ls, lv, ll, fr;

        do_reset();
        idle(1);

        // 1: load four words, back-to-back fetches
        load_prog(0);
        for (int i = 0; i < 4; i++) fetch(32'(i * 4));
        idle(2);

        // 2: unloaded, misaligned, out-of-range
        fetch(32'h10);
        fetch(32'h6);
        fetch(32'h100);
        idle(2);

        // 3: full-depth stream without load_last, then an extra word
        step(1, 0, '0, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, $urandom(), 0, 0, '0);
        step(0, 1, 32'hDEADBEEF, 0, 0, '0);
        fetch(32'hFC);
        fetch(32'h0);
        fetch(32'h80);
        idle(2);

        // 4: fetch coincident with load_start sees old contents
        step(1, 0, '0, 0, 1, 32'h0);
        idle(2);
        fetch(32'h0);        // ignored while loading
        step(0, 1, prog[0], 1, 0, '0);
        fetch(32'h0);
        fetch(32'h4);        // no longer loaded
        idle(2);

        // 5: reset in the middle of a load
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, prog[0], 0, 0, '0);
        step(0, 1, prog[1], 0, 0, '0);
        do_reset();
        fetch(32'h0);        // ignored in IDLE
        fetch(32'h4);
        load_prog(0);
        fetch(32'h0);
        fetch(32'h4);
        idle(2);

        // 6: gapped loading produces the same image
        load_prog(2);
        for (int i = 0; i < 5; i++) fetch(32'(i * 4));
        idle(2);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            ls = ($urandom_range(0, 39) == 0);
            lv = ($urandom_range(0, 1) == 1);
            ll = ($urandom_range(0, 5) == 0);
            fr = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                2:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                default: a = $urandom();
            endcase
            step(ls, lv, $urandom(), ll, fr, a);
        end
        idle(3);

        check_val("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
